// File: rtl/credito_moedas.sv
// Coin credit accumulator with greedy coin-by-coin change payout.
// Optional inactivity auto-refund: define CREDITO_TIMEOUT_EN.
module credito_moedas #(
    parameter int MAX_CREDIT     = 9999,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        moeda_valid,
    input  logic [2:0]  moeda_tipo,
    output logic        moeda_rejeitada,
    input  logic [13:0] preco,
    input  logic        comprar,
    input  logic        cancelar,
    output logic [13:0] centimos,
    output logic        produto,
    output logic        troco_valid,
    output logic [2:0]  troco_tipo,
    input  logic        troco_ready,
    output logic        ocupado
);

    localparam logic ACUM  = 1'b0;
    localparam logic TROCO = 1'b1;

    if (MAX_CREDIT > 16383 || MAX_CREDIT < 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("credito_moedas: invalid parameters");
    end

    function automatic logic [13:0] valor(input logic [2:0] t);
        unique case (t)
            3'd0:    valor = 14'd5;
            3'd1:    valor = 14'd10;
            3'd2:    valor = 14'd20;
            3'd3:    valor = 14'd50;
            3'd4:    valor = 14'd100;
            3'd5:    valor = 14'd200;
            default: valor = 14'd0;
        endcase
    endfunction

    // Largest coin not exceeding the remaining credit.
    function automatic logic [2:0] maior(input logic [13:0] c);
        if (c >= 14'd200)      maior = 3'd5;
        else if (c >= 14'd100) maior = 3'd4;
        else if (c >= 14'd50)  maior = 3'd3;
        else if (c >= 14'd20)  maior = 3'd2;
        else if (c >= 14'd10)  maior = 3'd1;
        else                   maior = 3'd0;
    endfunction

    logic        estado, nxt_estado;
    logic [13:0] nxt_cent;
    logic        nxt_rej, nxt_prod, aceite, tout_fire;
    logic [14:0] soma;
    logic        moeda_ok, compra_ok;

    assign soma      = {1'b0, centimos} + {1'b0, valor(moeda_tipo)};
    assign moeda_ok  = (valor(moeda_tipo) != 14'd0) && (soma <= 15'(MAX_CREDIT));
    assign compra_ok = (preco != 14'd0) && (preco % 14'd5 == 14'd0)
                       && (centimos >= preco);
    assign ocupado   = (estado == TROCO);

`ifdef CREDITO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;

    assign tout_fire = (estado == ACUM) && (centimos != 14'd0)
                       && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (estado == TROCO || centimos == 14'd0 || aceite
                     || nxt_estado == TROCO) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign tout_fire = 1'b0;
`endif

    always_comb begin
        nxt_estado = estado;
        nxt_cent   = centimos;
        nxt_rej    = 1'b0;
        nxt_prod   = 1'b0;
        aceite     = 1'b0;
        if (estado == ACUM) begin
            if (cancelar) begin
                if (centimos != 14'd0) nxt_estado = TROCO;
                nxt_rej = moeda_valid;
            end else if (comprar) begin
                if (compra_ok) begin
                    nxt_cent = centimos - preco;
                    nxt_prod = 1'b1;
                    aceite   = 1'b1;
                    if (centimos != preco) nxt_estado = TROCO;
                end
                nxt_rej = moeda_valid;
            end else if (moeda_valid) begin
                if (moeda_ok) begin
                    nxt_cent = soma[13:0];
                    aceite   = 1'b1;
                end else begin
                    nxt_rej = 1'b1;
                end
            end
            // Auto-refund only when nothing was accepted this cycle.
            if (!aceite && nxt_estado == ACUM && tout_fire) nxt_estado = TROCO;
        end else begin
            nxt_rej = moeda_valid;
            if (troco_valid && troco_ready) begin
                nxt_cent = centimos - valor(troco_tipo);
                if (nxt_cent == 14'd0) nxt_estado = ACUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado          <= ACUM;
            centimos        <= 14'd0;
            moeda_rejeitada <= 1'b0;
            produto         <= 1'b0;
            troco_valid     <= 1'b0;
            troco_tipo      <= 3'd0;
        end else begin
            estado          <= nxt_estado;
            centimos        <= nxt_cent;
            moeda_rejeitada <= nxt_rej;
            produto         <= nxt_prod;
            troco_valid     <= (nxt_estado == TROCO);
            troco_tipo      <= (nxt_estado == TROCO) ? maior(nxt_cent) : 3'd0;
        end
    end

endmodule

// File: tb/tb_credito_moedas.sv
// Bench for credito_moedas: vector table, hand sequences, random vs model.
module tb_credito_moedas;

`ifdef CREDITO_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1000000;
`endif
    localparam int MAXC = 9999;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        moeda_valid = 1'b0;
    logic [2:0]  moeda_tipo = 3'd0;
    logic        moeda_rejeitada;
    logic [13:0] preco = 14'd0;
    logic        comprar = 1'b0;
    logic        cancelar = 1'b0;
    logic [13:0] centimos;
    logic        produto;
    logic        troco_valid;
    logic [2:0]  troco_tipo;
    logic        troco_ready = 1'b0;
    logic        ocupado;

    credito_moedas #(.MAX_CREDIT(MAXC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .moeda_valid(moeda_valid), .moeda_tipo(moeda_tipo),
        .moeda_rejeitada(moeda_rejeitada),
        .preco(preco), .comprar(comprar), .cancelar(cancelar),
        .centimos(centimos), .produto(produto),
        .troco_valid(troco_valid), .troco_tipo(troco_tipo),
        .troco_ready(troco_ready), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int val [8] = '{5, 10, 20, 50, 100, 200, 0, 0};

    int m_cred, m_tt, m_cnt;
    bit m_busy, m_rej, m_prod, m_tv;

    function automatic int greedy(int c);
        for (int i = 5; i >= 0; i--) if (val[i] <= c) return i;
        return 0;
    endfunction

    function automatic void model_reset();
        m_cred = 0; m_tt = 0; m_cnt = 0;
        m_busy = 0; m_rej = 0; m_prod = 0; m_tv = 0;
    endfunction

    function automatic void model(bit v, int t, int p, bit buy, bit canc, bit rdy);
        bit acc = 0;
        bit was_busy = m_busy;
        int cred0 = m_cred;
        m_rej = 0;
        m_prod = 0;
        if (was_busy) begin
            m_rej = v;
            if (m_tv && rdy) begin
                m_cred -= val[m_tt];
                if (m_cred == 0) m_busy = 0;
            end
        end else if (canc) begin
            if (m_cred > 0) m_busy = 1;
            m_rej = v;
        end else if (buy) begin
            if (p > 0 && p % 5 == 0 && m_cred >= p) begin
                m_cred -= p;
                m_prod = 1;
                acc = 1;
                m_busy = (m_cred > 0);
            end
            m_rej = v;
        end else if (v) begin
            if (val[t] > 0 && m_cred + val[t] <= MAXC) begin
                m_cred += val[t];
                acc = 1;
            end else begin
                m_rej = 1;
            end
        end
`ifdef CREDITO_TIMEOUT_EN
        if (!was_busy && !m_busy && !acc && cred0 > 0 && m_cnt == TO - 1)
            m_busy = 1;
        if (was_busy || cred0 == 0 || acc || m_busy) m_cnt = 0;
        else m_cnt++;
`else
        if (cred0 < 0) m_cnt = 0;
`endif
        m_tv = m_busy;
        m_tt = m_busy ? greedy(m_cred) : 0;
    endfunction

    task automatic check_model(string name);
        logic [21:0] got, exp;
        got = {centimos, moeda_rejeitada, produto, troco_valid, troco_tipo, ocupado};
        exp = {m_cred[13:0], m_rej, m_prod, m_tv, m_tt[2:0], m_busy};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got cent=%0d rej=%0b prod=%0b tv=%0b tt=%0d busy=%0b, expected cent=%0d rej=%0b prod=%0b tv=%0b tt=%0d busy=%0b",
                     name, centimos, moeda_rejeitada, produto, troco_valid, troco_tipo, ocupado,
                     m_cred, m_rej, m_prod, m_tv, m_tt, m_busy);
        end
    endtask

    task automatic check_val(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic drive(bit v, int t, int p, bit buy, bit canc, bit rdy);
        logic [2:0] tt;
        logic [13:0] pp;
        tt = t[2:0];
        pp = p[13:0];
        moeda_valid = v; moeda_tipo = tt; preco = pp;
        comprar = buy; cancelar = canc; troco_ready = rdy;
        model(v, t, p, buy, canc, rdy);
        @(posedge clk);
        #1;
        moeda_valid = 0; comprar = 0; cancelar = 0;
        check_model("step");
    endtask

    task automatic do_reset();
        rst_n = 0;
        moeda_valid = 0; comprar = 0; cancelar = 0; troco_ready = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        check_model("reset");
    endtask

    typedef struct {
        bit v; int t; int p; bit buy; bit canc; bit rdy;
        int e_cent; bit e_rej; bit e_prod; bit e_tv; int e_tt; bit e_busy;
    } vec_t;

    vec_t tbl [24];

    initial begin
        // v t p buy canc rdy | cent rej prod tv tt busy
        tbl[0]  = '{1, 3, 0,   0, 0, 0,   50, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 4, 0,   0, 0, 0,  150, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 0,   0, 0, 0,  160, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 120, 1, 0, 1,   40, 0, 1, 1, 2, 1};
        tbl[4]  = '{0, 0, 120, 0, 0, 1,   20, 0, 0, 1, 2, 1};
        tbl[5]  = '{0, 0, 120, 0, 0, 1,    0, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 3, 0,   0, 0, 0,   50, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 2, 0,   0, 0, 0,   70, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 1, 0,   0, 0, 0,   80, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 0, 0,   0, 0, 0,   85, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 0,   0, 1, 0,   85, 0, 0, 1, 3, 1};
        tbl[11] = '{0, 0, 0,   0, 0, 0,   85, 0, 0, 1, 3, 1};
        tbl[12] = '{0, 0, 0,   0, 0, 0,   85, 0, 0, 1, 3, 1};
        tbl[13] = '{1, 0, 0,   0, 0, 0,   85, 1, 0, 1, 3, 1};
        tbl[14] = '{0, 0, 0,   0, 0, 1,   35, 0, 0, 1, 2, 1};
        tbl[15] = '{0, 0, 0,   0, 0, 1,   15, 0, 0, 1, 1, 1};
        tbl[16] = '{0, 0, 0,   0, 0, 1,    5, 0, 0, 1, 0, 1};
        tbl[17] = '{0, 0, 0,   0, 0, 1,    0, 0, 0, 0, 0, 0};
        tbl[18] = '{1, 4, 0,   0, 0, 0,  100, 0, 0, 0, 0, 0};
        tbl[19] = '{1, 0, 100, 1, 0, 0,    0, 1, 1, 0, 0, 0};
        tbl[20] = '{1, 4, 0,   0, 0, 0,  100, 0, 0, 0, 0, 0};
        tbl[21] = '{0, 0, 105, 1, 0, 0,  100, 0, 0, 0, 0, 0};
        tbl[22] = '{0, 0, 0,   1, 0, 0,  100, 0, 0, 0, 0, 0};
        tbl[23] = '{0, 0, 95,  1, 0, 0,    5, 0, 1, 1, 0, 1};

        do_reset();
        check_val("reset_cent", int'(centimos), 0);
        check_val("reset_tv", int'(troco_valid), 0);

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].v, tbl[i].t, tbl[i].p, tbl[i].buy, tbl[i].canc, tbl[i].rdy);
            check_val($sformatf("vec%0d_cent", i), int'(centimos), tbl[i].e_cent);
            check_val($sformatf("vec%0d_out", i),
                      int'({moeda_rejeitada, produto, troco_valid, troco_tipo, ocupado}),
                      int'({tbl[i].e_rej, tbl[i].e_prod, tbl[i].e_tv, 3'(tbl[i].e_tt), tbl[i].e_busy}));
        end

        // Credit ceiling
        do_reset();
        for (int i = 0; i < 49; i++) drive(1, 5, 0, 0, 0, 0);
        drive(1, 4, 0, 0, 0, 0);
        drive(1, 3, 0, 0, 0, 0);
        drive(1, 2, 0, 0, 0, 0);
        drive(1, 2, 0, 0, 0, 0);
        check_val("fill_9990", int'(centimos), 9990);
        drive(1, 1, 0, 0, 0, 0);
        check_val("over_cent", int'(centimos), 9990);
        check_val("over_rej", int'(moeda_rejeitada), 1);
        drive(1, 7, 0, 0, 0, 0);
        check_val("bad_code_rej", int'(moeda_rejeitada), 1);
        drive(1, 0, 0, 0, 0, 0);
        check_val("to_9995", int'(centimos), 9995);
        drive(0, 0, 0, 0, 0, 0);
        check_val("rej_clears", int'(moeda_rejeitada), 0);

        // Asynchronous reset in the middle of a payout
        do_reset();
        drive(1, 5, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        check_val("pre_rst_tv", int'(troco_valid), 1);
        #2 rst_n = 0;
        #1;
        check_val("async_rst", int'({centimos, troco_valid, troco_tipo, ocupado}), 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        check_model("post_rst");

`ifdef CREDITO_TIMEOUT_EN
        begin
            int n = 0;
            do_reset();
            drive(1, 2, 0, 0, 0, 0);
            while (!ocupado && n < 100) begin
                drive(0, 0, 0, 0, 0, 0);
                n++;
            end
            check_val("timeout_cycles", n, 16);
            check_val("timeout_tipo", int'(troco_tipo), 2);
            drive(0, 0, 0, 0, 0, 1);
            check_val("timeout_done", int'(centimos), 0);
        end
`endif

        // Random traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int r = $urandom_range(0, 19);
            bit rdy = 1'($urandom_range(0, 1));
            if (r < 12) begin
                drive(1, $urandom_range(0, 7), 0, 0, 0, rdy);
            end else if (r < 15) begin
                int p;
                if ($urandom_range(0, 7) == 0) p = $urandom_range(0, 16383);
                else p = 5 * $urandom_range(0, m_cred / 5 + 2);
                drive(0, 0, p, 1, 0, rdy);
            end else if (r == 15) begin
                drive(0, 0, 0, 0, 1, rdy);
            end else begin
                drive(0, 0, 0, 0, 0, rdy);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
